// File: rtl/ems_sdram_bridge.sv
// Wishbone classic memory slave that forwards each access through an external EMS
// address translator to an SDRAM controller. Define ZET_SDRAM_TIMEOUT_EN for the REQ watchdog.
module ems_sdram_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter logic [15:0] ERR_DATA       = 16'hFFFF
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [19:1] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [19:1] xlat_adr_o,
    input  logic [31:0] xlat_adr_i,
    output logic        sdram_req_o,
    output logic        sdram_we_o,
    output logic [31:0] sdram_adr_o,
    output logic [15:0] sdram_dat_o,
    output logic [1:0]  sdram_sel_o,
    input  logic        sdram_ack_i,
    input  logic [15:0] sdram_dat_i,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XLAT  = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [18:0] adr_r;
    logic [15:0] dat_r;
    logic [1:0]  sel_r;
    logic        we_r;
    logic [31:0] sdram_adr_r;
    logic        req_r;
    logic        wb_ack_r;
    logic [15:0] wb_dat_r;

    logic        req_nxt_s;
    logic        wb_ack_nxt_s;
    logic [15:0] wb_dat_nxt_s;

    logic        start_s;
    logic        in_xfer_s;
    logic        ack_ok_s;
    logic        complete_s;
    logic        tmo_hit_s;

    // The ack-cycle guard keeps a held strobe from being taken as a second request.
    assign start_s    = (state_r == ST_IDLE) & wb_cyc_i & wb_stb_i & ~wb_ack_r;
    assign in_xfer_s  = (state_r == ST_REQ) | (state_r == ST_DRAIN);
    assign ack_ok_s   = in_xfer_s & req_r & sdram_ack_i;
    assign complete_s = (state_r == ST_REQ) & (state_nxt_s == ST_DONE);

`ifdef ZET_SDRAM_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmo_r;
    logic          err_r;

    assign tmo_hit_s = (state_r == ST_REQ) & (tmo_r == TW'(TIMEOUT_CYCLES - 32'd1));
    assign err_o     = err_r;

    // REQ-cycle counter and sticky timeout flag
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tmo_r <= {TW{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (state_r != ST_REQ) begin
                tmo_r <= {TW{1'b0}};
            end else begin
                tmo_r <= tmo_r + TW'(1'b1);
            end
            if (complete_s && !ack_ok_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    logic unused_cfg_s;

    assign tmo_hit_s    = 1'b0;
    assign err_o        = 1'b0;
    assign unused_cfg_s = ^TIMEOUT_CYCLES;
`endif

    // State register
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an SDRAM ack outranks an abandoned cycle, which outranks the watchdog
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_XLAT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XLAT: begin
                if (!wb_cyc_i) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_ok_s) begin
                    state_nxt_s = wb_cyc_i ? ST_DONE : ST_IDLE;
                end else if (!wb_cyc_i) begin
                    state_nxt_s = ST_DRAIN;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (ack_ok_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        req_nxt_s    = 1'b0;
        wb_ack_nxt_s = 1'b0;
        wb_dat_nxt_s = wb_dat_r;
        // req rises one cycle after REQ is entered, matching the translator pipeline
        if (in_xfer_s && ((state_nxt_s == ST_REQ) || (state_nxt_s == ST_DRAIN))) begin
            req_nxt_s = 1'b1;
        end else begin
            req_nxt_s = 1'b0;
        end
        if (state_r == ST_DONE) begin
            wb_ack_nxt_s = 1'b1;
        end else begin
            wb_ack_nxt_s = 1'b0;
        end
        if (complete_s && !we_r) begin
            if (ack_ok_s) begin
                wb_dat_nxt_s = sdram_dat_i;
            end else begin
                wb_dat_nxt_s = ERR_DATA;
            end
        end else begin
            wb_dat_nxt_s = wb_dat_r;
        end
    end

    // Holding registers and registered outputs
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            adr_r       <= 19'h0_0000;
            dat_r       <= 16'h0000;
            sel_r       <= 2'b00;
            we_r        <= 1'b0;
            sdram_adr_r <= 32'h0000_0000;
            req_r       <= 1'b0;
            wb_ack_r    <= 1'b0;
            wb_dat_r    <= 16'h0000;
        end else begin
            req_r    <= req_nxt_s;
            wb_ack_r <= wb_ack_nxt_s;
            wb_dat_r <= wb_dat_nxt_s;
            if (start_s) begin
                adr_r <= wb_adr_i;
                dat_r <= wb_dat_i;
                sel_r <= wb_sel_i;
                we_r  <= wb_we_i;
            end else begin
                adr_r <= adr_r;
                dat_r <= dat_r;
                sel_r <= sel_r;
                we_r  <= we_r;
            end
            if (state_r == ST_XLAT) begin
                sdram_adr_r <= xlat_adr_i;
            end else begin
                sdram_adr_r <= sdram_adr_r;
            end
        end
    end

    assign xlat_adr_o  = adr_r;
    assign sdram_adr_o = sdram_adr_r;
    assign sdram_dat_o = dat_r;
    assign sdram_sel_o = sel_r;
    assign sdram_we_o  = we_r;
    assign sdram_req_o = req_r;
    assign wb_ack_o    = wb_ack_r;
    assign wb_dat_o    = wb_dat_r;

endmodule

// File: tb/tb_ems_sdram_bridge.sv
// Scoreboard bench for ems_sdram_bridge: stimulus pushes expected SDRAM requests and
// Wishbone completions; independent monitors pop and compare them.
module tb_ems_sdram_bridge;

    logic        clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [19:1] wb_adr_i = 19'h0;
    logic [15:0] wb_dat_i = 16'h0;
    logic [1:0]  wb_sel_i = 2'b00;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic [19:1] xlat_adr_o;
    logic [31:0] xlat_adr_i = 32'h0;
    logic        sdram_req_o;
    logic        sdram_we_o;
    logic [31:0] sdram_adr_o;
    logic [15:0] sdram_dat_o;
    logic [1:0]  sdram_sel_o;
    logic        sdram_ack_i = 1'b0;
    logic [15:0] sdram_dat_i = 16'h0;
    logic        err_o;

    always #5 clk = ~clk;

    ems_sdram_bridge #(.TIMEOUT_CYCLES(8), .ERR_DATA(16'hFFFF)) dut (
        .wb_clk(clk), .wb_rst(wb_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .xlat_adr_o(xlat_adr_o), .xlat_adr_i(xlat_adr_i),
        .sdram_req_o(sdram_req_o), .sdram_we_o(sdram_we_o), .sdram_adr_o(sdram_adr_o),
        .sdram_dat_o(sdram_dat_o), .sdram_sel_o(sdram_sel_o),
        .sdram_ack_i(sdram_ack_i), .sdram_dat_i(sdram_dat_i), .err_o(err_o)
    );

    typedef struct packed {
        logic [18:0] xadr;
        logic [31:0] adr;
        logic        we;
        logic [15:0] dat;
        logic [1:0]  sel;
    } req_t;

    req_t        exp_req_q[$];
    logic [15:0] exp_ack_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          req_rises = 0;
    logic [15:0] last_rd = 16'h0000;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor
    initial begin
        logic        prev_ack;
        logic [15:0] e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_ack_o) begin
                if (exp_ack_q.size() == 0) begin
                    chk("unexpected_ack", wb_ack_o, 1'b0);
                end else begin
                    e = exp_ack_q.pop_front();
                    chk("ack_data", wb_dat_o, e);
                end
                chk("no_req_in_ack_cycle", sdram_req_o, 1'b0);
                chk("ack_one_cycle", prev_ack, 1'b0);
            end
            prev_ack = wb_ack_o;
        end
    end

    // SDRAM request monitor
    initial begin
        logic   prev_req;
        logic   stable;
        req_t   cur;
        req_t   snap;
        prev_req = 1'b0;
        stable   = 1'b1;
        forever begin
            @(negedge clk);
            cur = {xlat_adr_o, sdram_adr_o, sdram_we_o, sdram_dat_o, sdram_sel_o};
            if (sdram_req_o && !prev_req) begin
                req_rises++;
                snap   = cur;
                stable = 1'b1;
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_req", sdram_req_o, 1'b0);
                end else begin
                    chk("req_fields", cur, exp_req_q.pop_front());
                end
            end else if (sdram_req_o) begin
                if (cur !== snap) stable = 1'b0;
            end else if (prev_req) begin
                chk("req_stable", stable, 1'b1);
            end
            prev_req = sdram_req_o;
        end
    end

    task automatic drive(input logic [18:0] adr, input logic [15:0] wdat, input logic [1:0] sel,
                         input logic we, input logic [31:0] xadr);
        wb_adr_i   = adr;
        wb_dat_i   = wdat;
        wb_sel_i   = sel;
        wb_we_i    = we;
        xlat_adr_i = xadr;
        wb_cyc_i   = 1'b1;
        wb_stb_i   = 1'b1;
    endtask

    task automatic wait_req();
        int i;
        i = 0;
        while (!sdram_req_o && i < 20) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic wait_ack();
        int i;
        i = 0;
        while (!wb_ack_o && i < 40) begin
            @(negedge clk);
            i++;
        end
    endtask

    // Full transfer; SDRAM ack is sampled n edges after the edge that raised req.
    task automatic xfer(input logic [18:0] adr, input logic [15:0] wdat, input logic [1:0] sel,
                        input logic we, input logic [31:0] xadr, input int n,
                        input logic [15:0] rdat, input bit hold);
        int t0;
        exp_req_q.push_back({adr, xadr, we, wdat, sel});
        if (!we) last_rd = rdat;
        exp_ack_q.push_back(last_rd);
        drive(adr, wdat, sel, we, xadr);
        if (wb_ack_o) @(posedge clk);
        @(posedge clk);
        #1;
        t0 = cyc_cnt;
        wait_req();
        chk("req_latency", cyc_cnt - t0, 2);
        repeat (n - 1) @(negedge clk);
        sdram_ack_i = 1'b1;
        sdram_dat_i = rdat;
        @(negedge clk);
        sdram_ack_i = 1'b0;
        sdram_dat_i = 16'h0000;
        chk("req_drop_after_ack", sdram_req_o, 1'b0);
        wait_ack();
        chk("ack_latency", cyc_cnt - t0, 3 + n);
        if (!hold) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    initial begin
        int  r0;
        int  acks;
        int  reqs;
        logic held;

        repeat (3) @(negedge clk);
        chk("reset_state", {wb_dat_o, wb_ack_o, xlat_adr_o, sdram_req_o, sdram_we_o,
                            sdram_adr_o, sdram_dat_o, sdram_sel_o, err_o}, 0);
        wb_rst = 1'b0;
        @(negedge clk);

        xfer(19'h0_1000, 16'h0000, 2'b11, 1'b0, 32'h0000_4000, 3, 16'hBEEF, 1'b0);
        xfer(19'h6_2000, 16'h1234, 2'b10, 1'b1, 32'h0012_8000, 2, 16'h0000, 1'b0);
        xfer(19'h2_0002, 16'h7777, 2'b00, 1'b1, 32'h0000_0004, 1, 16'h0000, 1'b0);

        r0 = req_rises;
        xfer(19'h0_0010, 16'h0000, 2'b11, 1'b0, 32'h0000_0100, 1, 16'h1111, 1'b1);
        xfer(19'h7_FFFF, 16'h0000, 2'b01, 1'b0, 32'hFFFF_FFFE, 4, 16'h2222, 1'b0);
        repeat (4) @(negedge clk);
        chk("b2b_req_count", req_rises - r0, 2);

        // Cycle abandoned in REQ: request must run to the SDRAM ack, no completion
        exp_req_q.push_back({19'h1_2345, 32'h0ABC_0000, 1'b0, 16'h0000, 2'b11});
        drive(19'h1_2345, 16'h0000, 2'b11, 1'b0, 32'h0ABC_0000);
        @(negedge clk);
        wait_req();
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        held = 1'b1;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            held = held & sdram_req_o;
            acks += int'(wb_ack_o);
        end
        chk("drain_req_held", held, 1'b1);
        sdram_ack_i = 1'b1;
        sdram_dat_i = 16'h9999;
        @(negedge clk);
        sdram_ack_i = 1'b0;
        chk("drain_req_drop", sdram_req_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            acks += int'(wb_ack_o);
        end
        chk("drain_no_ack", acks, 0);

        xfer(19'h0_4444, 16'h0000, 2'b11, 1'b0, 32'h0002_2220, 2, 16'hCAFE, 1'b0);

`ifdef ZET_SDRAM_TIMEOUT_EN
        exp_req_q.push_back({19'h0_0777, 32'h0000_1EEE, 1'b0, 16'h0000, 2'b01});
        last_rd = 16'hFFFF;
        exp_ack_q.push_back(last_rd);
        drive(19'h0_0777, 16'h0000, 2'b01, 1'b0, 32'h0000_1EEE);
        @(negedge clk);
        wait_ack();
        chk("tmo_ack_seen", wb_ack_o, 1'b1);
        chk("tmo_err_set", err_o, 1'b1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", err_o, 1'b1);
`endif

        // Reset in the middle of a write, then a stray late ack
        exp_req_q.push_back({19'h2_3456, 32'h0000_9990, 1'b1, 16'hA55A, 2'b11});
        drive(19'h2_3456, 16'hA55A, 2'b11, 1'b1, 32'h0000_9990);
        @(negedge clk);
        wait_req();
        chk("rst_req_seen", sdram_req_o, 1'b1);
        @(negedge clk);
        wb_rst   = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
        wb_rst  = 1'b0;
        last_rd = 16'h0000;
        chk("rst_outputs", {wb_dat_o, wb_ack_o, xlat_adr_o, sdram_req_o, sdram_we_o,
                            sdram_adr_o, sdram_dat_o, sdram_sel_o, err_o}, 0);
        sdram_ack_i = 1'b1;
        sdram_dat_i = 16'hDEAD;
        @(negedge clk);
        sdram_ack_i = 1'b0;
        sdram_dat_i = 16'h0000;
        acks = 0;
        reqs = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acks += int'(wb_ack_o);
            reqs += int'(sdram_req_o);
        end
        chk("stray_ack_ignored", {acks, reqs}, 0);

        xfer(19'h5_0505, 16'h0000, 2'b11, 1'b0, 32'h0100_0A0A, 2, 16'h5A5A, 1'b0);

        repeat (5) @(negedge clk);
        chk("ack_queue_empty", exp_ack_q.size(), 0);
        chk("req_queue_empty", exp_req_q.size(), 0);
        chk("err_clear_after_reset", err_o, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ems_sdram_bridge.md
EMS_SDRAM_BRIDGE -- requirements
Module: ems_sdram_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, SDRAM wait limit in clocks before an error completion (used only with ZET_SDRAM_TIMEOUT_EN).
REQ-002 Parameter: ERR_DATA, default 16'hFFFF, read data returned on a timed-out access.
REQ-003 wb_clk  in  1  single clock; all logic on rising edge.
REQ-004 wb_rst  in  1  synchronous, active-high reset.
REQ-005 wb_adr_i  in  19 [19:1]; wb_dat_i  in  16; wb_sel_i  in  2; wb_cyc_i, wb_stb_i, wb_we_i  in  1 each; CPU-side Wishbone classic memory slave.
REQ-006 wb_dat_o  out  16  read data; wb_ack_o  out  1  one-cycle completion pulse.
REQ-007 xlat_adr_o  out  19  [19:1] latched CPU address, drives the EMS translator input.
REQ-008 xlat_adr_i  in  32  translated address returned combinationally by the EMS translator.
REQ-009 sdram_req_o  out  1; sdram_we_o  out  1; sdram_adr_o  out  32; sdram_dat_o  out  16; sdram_sel_o  out  2; request to the SDRAM controller.
REQ-010 sdram_ack_i  in  1  completion strobe; sdram_dat_i  in  16  read data, valid when sdram_ack_i=1.
REQ-011 err_o  out  1  sticky timeout flag.

Function
REQ-012 FSM states: IDLE, XLAT, REQ, DONE, DRAIN.
REQ-013 IDLE: when wb_cyc_i & wb_stb_i & ~wb_ack_o, latch adr/dat/sel/we into holding registers and go to XLAT.
REQ-014 xlat_adr_o shall always equal the latched address register, never wb_adr_i directly.
REQ-015 XLAT: register xlat_adr_i into sdram_adr_o; go to REQ.
REQ-016 REQ: sdram_req_o=1 with sdram_adr_o, sdram_we_o, sdram_dat_o, sdram_sel_o stable until sdram_ack_i=1.
REQ-017 On sdram_ack_i in REQ: sdram_req_o=0 next cycle; read data captured into wb_dat_o; go to DONE.
REQ-018 DONE: wb_ack_o=1 for exactly one cycle; go to IDLE; IDLE shall not accept a new request in the cycle wb_ack_o is high.
REQ-019 Latency: stb sampled at edge 0, sdram_req_o high after edge 2, sdram_ack_i at edge 2+n, wb_ack_o high after edge 3+n.
REQ-020 wb_dat_o holds last read (or error) data until next read completion; writes leave it unchanged.
REQ-021 wb_cyc_i dropped while in XLAT or REQ: request is not aborted; go to DRAIN, keep sdram_req_o until sdram_ack_i, then IDLE with no wb_ack_o.
REQ-022 sdram_ack_i outside REQ/DRAIN shall be ignored.
REQ-023 wb_sel_i=2'b00 shall still complete normally (SDRAM access with sdram_sel_o=0).

Reset
REQ-024 wb_rst has priority over all events, including mid-transfer: state=IDLE, sdram_req_o=0, wb_ack_o=0, wb_dat_o=0, sdram_adr_o=0, sdram_dat_o=0, sdram_sel_o=0, sdram_we_o=0, xlat_adr_o=0, err_o=0, timeout counter=0.
REQ-025 An SDRAM transfer in flight at reset is abandoned; a late sdram_ack_i after reset is ignored per REQ-022.

Configuration
REQ-026 Macro ZET_SDRAM_TIMEOUT_EN defined: a counter clears on entering REQ, increments each REQ cycle; when it reaches TIMEOUT_CYCLES without sdram_ack_i, drop sdram_req_o, load ERR_DATA into wb_dat_o (reads only), set err_o, go to DONE.
REQ-027 ZET_SDRAM_TIMEOUT_EN defined: err_o clears only on wb_rst; DRAIN is not subject to timeout.
REQ-028 ZET_SDRAM_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, err_o tied 0.

Verification
REQ-029 Read adr 19'h0_1000, xlat_adr_i=32'h0000_4000, sdram_ack_i 3 cycles after req with dat 16'hBEEF -> sdram_adr_o=32'h4000, wb_dat_o=16'hBEEF, wb_ack_o one cycle at edge 6.
REQ-030 Write adr 19'h6_2000 dat 16'h1234 sel 2'b10, xlat_adr_i=32'h0012_8000 -> sdram_we_o=1, sdram_dat_o=16'h1234, sdram_sel_o=2'b10, sdram_adr_o=32'h0012_8000, one wb_ack_o.
REQ-031 Two back-to-back reads, stb held high through ack -> exactly two SDRAM requests, two wb_ack_o pulses, no request issued in ack cycle.
REQ-032 wb_cyc_i dropped 1 cycle into REQ, sdram_ack_i 5 cycles later -> sdram_req_o held until ack, no wb_ack_o, return to IDLE.
REQ-033 With ZET_SDRAM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no sdram_ack_i -> sdram_req_o drops after 8 REQ cycles, wb_dat_o=16'hFFFF, wb_ack_o pulse, err_o=1 until wb_rst.
REQ-034 wb_rst asserted during REQ -> next cycle all outputs at reset values; subsequent stray sdram_ack_i produces no wb_ack_o.
